// File: rtl/dog_extrema_filter.sv
`default_nettype none
// ============================================================================
// Module   : dog_extrema_filter
// Brief    : Keeps a 3-sample window along the serpentine-scanned DoG stream,
//            flags thresholded local maxima/minima away from the row borders
//            and queues them as keypoints in a first-word-fall-through FIFO
//            with a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dog_extrema_filter #(
    parameter int WIDTH      = 251,
    parameter int BORDER     = 2,
    parameter int THRESH     = 8,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Directionin,
    input  logic [7:0]         Xin,
    input  logic [7:0]         Yin,
    input  logic signed [16:0] DoGin,
    output logic               kp_valid,
    input  logic               kp_ready,
    output logic [7:0]         kp_x,
    output logic [7:0]         kp_y,
    output logic               kp_pol,
    output logic signed [16:0] kp_dog,
    output logic [15:0]        drop_count
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_WW = $clog2(WARMUP + 2);

    localparam logic [c_WW-1:0]    c_WARM   = c_WW'(WARMUP);
    localparam logic [c_CW-1:0]    c_DEPTH  = c_CW'(FIFO_DEPTH);
    localparam logic [7:0]         c_XLO    = 8'(BORDER);
    localparam logic [7:0]         c_XHI    = 8'(WIDTH - BORDER);
    localparam logic signed [16:0] c_POS_TH = 17'(THRESH);
    localparam logic signed [16:0] c_NEG_TH = -c_POS_TH;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        pol;
        logic [16:0] dog;
    } kp_t;

    // ------------------------------------------------------------------
    // Warmup: the DoG pipeline is still filling, so ignore its output
    // ------------------------------------------------------------------
    logic [c_WW-1:0] r_warm;
    logic            w_capture;

    assign w_capture = (r_warm == c_WARM);

    // Count edges after reset release until capture is enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_warm <= '0;
        end else if (!w_capture) begin
            r_warm <= r_warm + c_WW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Window. Older entries keep only the fields that are read later:
    // s2 needs y/dir for the row-turn test, s1 needs x/y for the keypoint,
    // s0 only participates in the value comparison.
    // ------------------------------------------------------------------
    logic signed [16:0] r_s0_dog;
    logic [7:0]         r_s1_x;
    logic [7:0]         r_s1_y;
    logic signed [16:0] r_s1_dog;
    logic [7:0]         r_s2_x;
    logic [7:0]         r_s2_y;
    logic               r_s2_dir;
    logic signed [16:0] r_s2_dog;
    logic [1:0]         r_fill;

    // Shift the window each capturing edge; a row turn restarts the fill
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0_dog <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_dog <= '0;
            r_s2_x   <= '0;
            r_s2_y   <= '0;
            r_s2_dir <= 1'b0;
            r_s2_dog <= '0;
            r_fill   <= 2'd0;
        end else if (w_capture) begin
            r_s0_dog <= r_s1_dog;
            r_s1_x   <= r_s2_x;
            r_s1_y   <= r_s2_y;
            r_s1_dog <= r_s2_dog;
            r_s2_x   <= Xin;
            r_s2_y   <= Yin;
            r_s2_dir <= Directionin;
            r_s2_dog <= DoGin;
            if ((Yin != r_s2_y) || (Directionin != r_s2_dir)) begin
                r_fill <= 2'd1;
            end else if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Extremum detection on the centre sample (strict, so plateaus never fire)
    // ------------------------------------------------------------------
    logic w_in_border;
    logic w_is_max;
    logic w_is_min;
    logic w_hit;
    kp_t  w_new;

    assign w_in_border = (r_s1_x >= c_XLO) && (r_s1_x <= c_XHI);
    assign w_is_max    = (r_s1_dog > r_s0_dog) && (r_s1_dog > r_s2_dog) &&
                         (r_s1_dog >= c_POS_TH);
    assign w_is_min    = (r_s1_dog < r_s0_dog) && (r_s1_dog < r_s2_dog) &&
                         (r_s1_dog <= c_NEG_TH);
    assign w_hit       = (r_fill == 2'd3) && w_in_border && (w_is_max || w_is_min);
    assign w_new       = {r_s1_x, r_s1_y, w_is_max, r_s1_dog};

    // ------------------------------------------------------------------
    // Keypoint FIFO
    // ------------------------------------------------------------------
    kp_t             r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [c_CW-1:0] r_cnt;
    logic [15:0]     r_drop;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_PW-1:0] w_head_ptr;
    kp_t             w_head;

    assign w_full   = (r_cnt == c_DEPTH);
    assign kp_valid = (r_cnt != '0);
    assign w_pop    = kp_valid && kp_ready;
    assign w_push   = w_hit && (!w_full || w_pop);
    assign w_drop   = w_hit && w_full && !w_pop;

    // When empty, point at the slot popped last so the head holds its value;
    // that slot cannot be rewritten before the queue wraps all the way round.
    assign w_head_ptr = kp_valid ? r_rd : (r_rd - c_PW'(1));
    assign w_head     = r_mem[w_head_ptr];

    assign kp_x       = w_head.x;
    assign kp_y       = w_head.y;
    assign kp_pol     = w_head.pol;
    assign kp_dog     = w_head.dog;
    assign drop_count = r_drop;

    // Storage, pointers and occupancy; push and pop may share an edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_new;
                r_wr        <= r_wr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Saturating count of keypoints lost to a full queue
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dog_extrema_filter
// Brief    : Directed scoreboard bench for dog_extrema_filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dog_extrema_filter;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        pol;
        logic [16:0] dog;
    } kp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               Directionin;
    logic [7:0]         Xin;
    logic [7:0]         Yin;
    logic signed [16:0] DoGin;
    logic               kp_valid;
    logic               kp_ready;
    logic [7:0]         kp_x;
    logic [7:0]         kp_y;
    logic               kp_pol;
    logic signed [16:0] kp_dog;
    logic [15:0]        drop_count;

    int  total = 0;
    int  bad   = 0;
    kp_t exp_q[$];

    dog_extrema_filter dut (
        .clk        (clk),
        .rst        (rst),
        .Directionin(Directionin),
        .Xin        (Xin),
        .Yin        (Yin),
        .DoGin      (DoGin),
        .kp_valid   (kp_valid),
        .kp_ready   (kp_ready),
        .kp_x       (kp_x),
        .kp_y       (kp_y),
        .kp_pol     (kp_pol),
        .kp_dog     (kp_dog),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic kp_t mk(input int x, input int y, input bit pol, input int dog);
        kp_t k;
        k.x   = 8'(x);
        k.y   = 8'(y);
        k.pol = pol;
        k.dog = 17'(dog);
        return k;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Present one sample, let it be clocked in, return 1 time unit after the edge
    task automatic drive(input int x, input int y, input int d, input int dog);
        Xin         = 8'(x);
        Yin         = 8'(y);
        Directionin = d[0];
        DoGin       = 17'(dog);
        @(posedge clk);
        #1;
    endtask

    task automatic filler(input int n);
        repeat (n) drive(100, 200, 0, 0);
    endtask

    // Three samples centred on xc in row y, then one separating filler
    task automatic trip(input int xc, input int y, input int a, input int b, input int c,
                        input bit hit, input bit pol);
        drive(xc - 1, y, 0, a);
        if (hit) exp_q.push_back(mk(xc, y, pol, b));
        drive(xc, y, 0, b);
        drive(xc + 1, y, 0, c);
        filler(1);
    endtask

    // Monitor: every accepted head is checked against the scoreboard
    initial begin
        kp_t got;
        forever begin
            @(negedge clk);
            if (rst && kp_valid && kp_ready) begin
                got = {kp_x, kp_y, kp_pol, kp_dog};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_kp: got %0h required none", got);
                end else begin
                    if (got !== exp_q[0]) begin
                        bad++;
                        $display("FAIL kp_content: got %0h required %0h", got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        kp_ready = 1'b1;
        Xin = 8'd10; Yin = 8'd5; Directionin = 1'b0; DoGin = 17'sd100;

        // Reset and warmup: samples during warmup must not form a window
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {kp_valid, kp_x, kp_y, kp_pol, kp_dog, drop_count},
            {1'b0, 8'd0, 8'd0, 1'b0, 17'd0, 16'd0});
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(10, 5, 0, 100);
            chk("warmup_valid", {63'd0, kp_valid}, 64'd0);
        end
        drive(11, 5, 0, -50);
        repeat (5) drive(12, 5, 0, 0);
        chk("warmup_none", {47'd0, kp_valid, drop_count}, 64'd0);

        // Single maximum with latency check
        filler(2);
        drive(20, 7, 0, 3);
        exp_q.push_back(mk(21, 7, 1, 50));
        drive(21, 7, 0, 50);
        drive(22, 7, 0, 4);
        chk("max_lat_early", {63'd0, kp_valid}, 64'd0);
        filler(1);
        chk("max_lat_valid", {55'd0, kp_valid, kp_x}, {55'd0, 1'b1, 8'd21});
        filler(3);

        // Minimum, threshold edge cases
        trip(31, 9, -2, -9, -1, 1'b1, 1'b0);
        trip(41, 9, -2, -7, -1, 1'b0, 1'b0);
        trip(51, 15, 0, -8, 0, 1'b1, 1'b0);
        trip(61, 16, 0, 7, 0, 1'b0, 1'b0);
        trip(71, 17, 0, 8, 0, 1'b1, 1'b1);
        trip(81, 18, 5, 20, 20, 1'b0, 1'b0);

        // Row turn (y change and direction-only change) restarts the window
        drive(250, 3, 0, 5); drive(250, 4, 1, 90); drive(249, 4, 1, 5); filler(1);
        drive(100, 3, 0, 5); drive(100, 4, 1, 90); drive(99, 4, 1, 5); filler(1);
        drive(100, 30, 0, 5); drive(101, 30, 1, 90); drive(100, 30, 1, 5); filler(1);

        // Border: x=1 and x=250 suppressed, x=2 and x=249 emitted
        trip(1, 11, 0, 60, 0, 1'b0, 1'b1);
        trip(2, 12, 0, 60, 0, 1'b1, 1'b1);
        trip(249, 13, 0, 60, 0, 1'b1, 1'b1);
        trip(250, 14, 0, 60, 0, 1'b0, 1'b1);
        filler(4);
        chk("drained_before_ovf", {63'd0, kp_valid}, 64'd0);

        // Overflow under backpressure: 8 queued, 2 dropped, head stable
        kp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            trip(11, 20 + i, 0, 100 + i, 0, (i < 8), 1'b1);
            chk("head_stable", {38'd0, kp_valid, kp_x, kp_dog},
                {38'd0, 1'b1, 8'd11, 17'd100});
        end
        filler(2);
        chk("drop_after_ovf", {48'd0, drop_count}, 64'd2);
        kp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_valid", {63'd0, kp_valid}, 64'd1);
            filler(1);
        end
        chk("drain_empty", {63'd0, kp_valid}, 64'd0);

        // Full queue with a pop on the same edge as a push
        kp_ready = 1'b0;
        for (int i = 0; i < 8; i++) trip(11, 40 + i, 0, 200 + i, 0, 1'b1, 1'b1);
        drive(10, 48, 0, 0);
        exp_q.push_back(mk(11, 48, 1, 250));
        drive(11, 48, 0, 250);
        drive(12, 48, 0, 0);
        kp_ready = 1'b1;
        filler(1);
        kp_ready = 1'b0;
        chk("drop_full_pushpop", {48'd0, drop_count}, 64'd2);
        filler(2);
        kp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("full_occ_valid", {63'd0, kp_valid}, 64'd1);
            filler(1);
        end
        chk("full_occ_empty", {63'd0, kp_valid}, 64'd0);

        // Mid-stream reset flushes queue and drop count
        kp_ready = 1'b0;
        trip(11, 60, 0, 77, 0, 1'b0, 1'b1);
        chk("pre_reset_valid", {63'd0, kp_valid}, 64'd1);
        rst = 1'b0;
        filler(1);
        rst = 1'b1;
        chk("midreset_state", {kp_valid, kp_x, kp_y, kp_pol, kp_dog, drop_count},
            {1'b0, 8'd0, 8'd0, 1'b0, 17'd0, 16'd0});
        kp_ready = 1'b1;
        filler(4);
        trip(11, 61, 0, 33, 0, 1'b1, 1'b1);
        filler(4);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
